// File: rtl/config_frame_transmitter_pkg.sv
// Shared types for the synth configuration frame and its transmit protocol.
// Optional macro TX_CHECKSUM_EN adds the checksum state to tx_state_t.
package config_frame_transmitter_pkg;

   // Width of the volume and reverb fields.
   localparam int unsigned WORD_W = 32;
   localparam int unsigned NUM_WAVE_GENS = 2;

   typedef struct packed {
      logic [15:0] freq;
      logic [7:0]  shape;
      logic [7:0]  level;
   } wavegen_t;

   // Field order sets wire order: volume leaves first, MSB byte first.
   typedef struct packed {
      logic [WORD_W-1:0]                  volume;
      logic [WORD_W-1:0]                  reverb;
      wavegen_t [NUM_WAVE_GENS-1:0]       wave_gens;
   } synth_t;

   localparam int unsigned SYNTH_BITS = $bits(synth_t);

   // Checksum word is as wide as one stream word.
   localparam int unsigned CSUM_W_DEFAULT = 8;

`ifdef TX_CHECKSUM_EN
   typedef enum logic [1:0] {StIdle, StSend, StCsum, StFinish} tx_state_t;
`else
   typedef enum logic [1:0] {StIdle, StSend, StFinish} tx_state_t;
`endif

   // Payload words per frame for a given stream word width.
   function automatic int unsigned frame_words(input int unsigned width);
      return SYNTH_BITS / width;
   endfunction

endpackage

// File: rtl/config_frame_transmitter_piso_shifter.sv
// Parallel-in/serial-out shifter: loads a full vector, shifts left by WIDTH
// on each advance strobe and always exposes the top WIDTH bits.
module config_frame_transmitter_piso_shifter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 128
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic             advance,
   input  logic [DEPTH-1:0] data_in,
   output logic [WIDTH-1:0] word
);

   logic [DEPTH-1:0] sreg;

   // Load has priority over advance; zeros fill from the bottom.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= data_in;
      end else if (advance) begin
         sreg <= sreg << WIDTH;
      end
   end

   assign word = sreg[DEPTH-1 -: WIDTH];

endmodule

// File: rtl/config_frame_transmitter.sv
// Streams a snapshot of synth_t as WIDTH-bit words over valid/ready, MSB word
// first, matching the config receiver's byte layout.
// Optional macro TX_CHECKSUM_EN appends an XOR checksum word to each frame.
module config_frame_transmitter
   import config_frame_transmitter_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned WORD  = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  synth_t           conf_in,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             tx_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned FRAME_WORDS = frame_words(WIDTH);
   localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);
`ifdef TX_CHECKSUM_EN
   localparam logic LAST_ON_FIRST = 1'b0;
`else
   localparam logic LAST_ON_FIRST = (FRAME_WORDS == 1);
`endif

   if (((SYNTH_BITS % WIDTH) != 0) || (WORD != WORD_W)) begin : g_bad_param
      $error("config_frame_transmitter: WIDTH must divide synth_t and WORD must match");
   end

   tx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             xfer;
   logic             load;
   logic             advance;
   logic [WIDTH-1:0] shift_word;

   assign xfer    = tx_valid && tx_ready;
   assign load    = (state == StIdle) && start;
   assign advance = xfer && (state == StSend);

   config_frame_transmitter_piso_shifter #(
      .WIDTH (WIDTH),
      .DEPTH (SYNTH_BITS)
   ) u_piso (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load),
      .advance (advance),
      .data_in (conf_in),
      .word    (shift_word)
   );

`ifdef TX_CHECKSUM_EN
   logic [WIDTH-1:0] csum;

   // Running XOR of every payload word accepted since the last latch.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         csum <= '0;
      end else if (load) begin
         csum <= '0;
      end else if (advance) begin
         csum <= csum ^ shift_word;
      end
   end

   assign tx_data = (state == StCsum) ? csum : shift_word;
`else
   assign tx_data = shift_word;
`endif

   // Frame sequencer with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= StIdle;
         cnt      <= '0;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state    <= StSend;
                  cnt      <= '0;
                  tx_valid <= 1'b1;
                  tx_last  <= LAST_ON_FIRST;
                  busy     <= 1'b1;
               end
            end
            StSend: begin
               if (xfer) begin
                  if (cnt == LAST_IDX) begin
`ifdef TX_CHECKSUM_EN
                     state   <= StCsum;
                     tx_last <= 1'b1;
`else
                     state    <= StFinish;
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
`ifdef TX_CHECKSUM_EN
                     tx_last <= 1'b0;
`else
                     tx_last <= ((cnt + CNT_W'(1)) == LAST_IDX);
`endif
                  end
               end
            end
`ifdef TX_CHECKSUM_EN
            StCsum: begin
               if (xfer) begin
                  state    <= StFinish;
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  done     <= 1'b1;
               end
            end
`endif
            StFinish: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_config_frame_transmitter.sv
// Directed bench for config_frame_transmitter; the TX_CHECKSUM_EN build also
// runs the checksum scenario.
module tb_config_frame_transmitter;
   import config_frame_transmitter_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned FW = SYNTH_BITS / WIDTH;
`ifdef TX_CHECKSUM_EN
   localparam int unsigned FLEN = FW + 1;
`else
   localparam int unsigned FLEN = FW;
`endif

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   synth_t           conf_in;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx_last;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] got_data[$];
   logic       got_last[$];
   int         done_at;
   int         done_cnt;
   int         valid_at;

   // A1..04 from volume/reverb, then wave_gens[1] and wave_gens[0]; last entry is their XOR.
   logic [7:0] exp_basic [0:16] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                    8'h88};

   always #5 clk = ~clk;

   config_frame_transmitter #(
      .WIDTH (WIDTH),
      .WORD  (32)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .conf_in  (conf_in),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .busy     (busy),
      .done     (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_basic_conf();
      conf_in.volume       = 32'hA1B2C3D4;
      conf_in.reverb       = 32'h01020304;
      conf_in.wave_gens[1] = '{freq: 16'h1122, shape: 8'h33, level: 8'h44};
      conf_in.wave_gens[0] = '{freq: 16'h5566, shape: 8'h77, level: 8'h88};
   endtask

   // Records accepted words and done pulses; cycle 1 is the sample after the start edge.
   task automatic collect(input int restart_at);
      got_data.delete();
      got_last.delete();
      done_at  = -1;
      done_cnt = 0;
      valid_at = -1;
      for (int cyc = 1; cyc <= int'(FLEN) + 12; cyc++) begin
         start = 1'b0;
         if (tx_valid && valid_at < 0) valid_at = cyc;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
         end
         if (restart_at >= 0 && tx_valid && got_data.size() == restart_at) begin
            start   = 1'b1;
            conf_in = '1;
         end
         if (tx_valid && tx_ready) begin
            got_data.push_back(tx_data);
            got_last.push_back(tx_last);
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      start    = 1'b0;
      tx_ready = 1'b1;
      conf_in  = '0;
      step(); step(); step();
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
      n_cmp++; if (tx_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", tx_last); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", tx_data); end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_basic();
      set_basic_conf();
      tx_ready = 1'b1;
      start    = 1'b1;
      step();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
      collect(-1);
      n_cmp++; if (valid_at !== 1) begin n_err++; $display("FAIL basic_latency: got %0d want 1", valid_at); end
      n_cmp++;
      if (got_data.size() !== FLEN) begin
         n_err++; $display("FAIL basic_count: got %0d want %0d", got_data.size(), FLEN);
      end
      for (int k = 0; k < int'(FLEN) && k < got_data.size(); k++) begin
         n_cmp++;
         if (got_data[k] !== exp_basic[k]) begin
            n_err++; $display("FAIL basic_word%0d: got %h want %h", k, got_data[k], exp_basic[k]);
         end
         n_cmp++;
         if (got_last[k] !== (k == int'(FLEN) - 1)) begin
            n_err++; $display("FAIL basic_last%0d: got %b want %b", k, got_last[k], k == int'(FLEN) - 1);
         end
      end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
      // Sample FLEN+1 after the start edge: FLEN+2 cycles counting the start cycle.
      n_cmp++;
      if (done_at !== int'(FLEN) + 1) begin
         n_err++; $display("FAIL basic_done_at: got %0d want %0d", done_at, FLEN + 1);
      end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      int  k;
      int  cyc;
      int  n_done;
      int  d_at;
      bit  stalled;
      k = 0; cyc = 1; n_done = 0; d_at = -1; stalled = 0;
      set_basic_conf();
      tx_ready = 1'b1;
      start    = 1'b1;
      step();
      start = 1'b0;
      while (cyc <= int'(FLEN) + 20) begin
         if (done) begin
            n_done++;
            if (d_at < 0) d_at = cyc;
         end
         if (tx_valid && k == 5 && !stalled) begin
            stalled  = 1;
            tx_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               step(); cyc++;
               n_cmp++; if (tx_data !== 8'h02) begin n_err++; $display("FAIL bp_hold_data%0d: got %h want 02", i, tx_data); end
               n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, tx_valid); end
               n_cmp++; if (tx_last !== 1'b0) begin n_err++; $display("FAIL bp_hold_last%0d: got %b want 0", i, tx_last); end
            end
            tx_ready = 1'b1;
         end
         if (tx_valid && tx_ready) begin
            n_cmp++;
            if (k > 16 || tx_data !== exp_basic[k]) begin
               n_err++; $display("FAIL bp_word%0d: got %h", k, tx_data);
            end
            k++;
         end
         step(); cyc++;
      end
      n_cmp++; if (k !== int'(FLEN)) begin n_err++; $display("FAIL bp_count: got %0d want %0d", k, FLEN); end
      n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL bp_done_cnt: got %0d want 1", n_done); end
      n_cmp++;
      if (d_at !== int'(FLEN) + 4) begin
         n_err++; $display("FAIL bp_done_at: got %0d want %0d", d_at, FLEN + 4);
      end
   endtask

   task automatic test_restart_ignored();
      set_basic_conf();
      tx_ready = 1'b1;
      start    = 1'b1;
      step();
      collect(2);
      n_cmp++;
      if (got_data.size() !== FLEN) begin
         n_err++; $display("FAIL rs_count: got %0d want %0d", got_data.size(), FLEN);
      end
      for (int k = 0; k < int'(FLEN) && k < got_data.size(); k++) begin
         n_cmp++;
         if (got_data[k] !== exp_basic[k]) begin
            n_err++; $display("FAIL rs_word%0d: got %h want %h", k, got_data[k], exp_basic[k]);
         end
      end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rs_done_cnt: got %0d want 1", done_cnt); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rs_no_requeue: got %b want 0", tx_valid); end
      set_basic_conf();
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      bad = 0;
      set_basic_conf();
      tx_ready = 1'b1;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++; if (tx_data !== 8'h01) begin n_err++; $display("FAIL rm_word4: got %h want 01", tx_data); end
      rstn = 1'b0;
      step();
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", tx_valid); end
      n_cmp++; if (tx_last !== 1'b0) begin n_err++; $display("FAIL rm_last: got %b want 0", tx_last); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rm_data: got %h want 00", tx_data); end
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done !== 1'b0 || tx_valid !== 1'b0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rm_quiet: got %0d active cycles want 0", bad); end
      start = 1'b1;
      step();
      collect(-1);
      n_cmp++;
      if (got_data.size() !== FLEN) begin
         n_err++; $display("FAIL rm_count: got %0d want %0d", got_data.size(), FLEN);
      end
      for (int k = 0; k < int'(FLEN) && k < got_data.size(); k++) begin
         n_cmp++;
         if (got_data[k] !== exp_basic[k]) begin
            n_err++; $display("FAIL rm_word%0d: got %h want %h", k, got_data[k], exp_basic[k]);
         end
      end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rm_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_loopback();
      synth_t sent;
      synth_t r;
      sent.volume = $urandom();
      sent.reverb = $urandom();
      for (int g = 0; g < int'(NUM_WAVE_GENS); g++) sent.wave_gens[g] = wavegen_t'($urandom());
      conf_in  = sent;
      tx_ready = 1'b1;
      start    = 1'b1;
      step();
      collect(-1);
      // Byte-wise receiver: each accepted word shifts in at the bottom.
      r = '0;
      for (int k = 0; k < int'(FW) && k < got_data.size(); k++) begin
         r = synth_t'({r[SYNTH_BITS-WIDTH-1:0], got_data[k]});
      end
      n_cmp++; if (r.volume !== sent.volume) begin n_err++; $display("FAIL lb_volume: got %h want %h", r.volume, sent.volume); end
      n_cmp++; if (r.reverb !== sent.reverb) begin n_err++; $display("FAIL lb_reverb: got %h want %h", r.reverb, sent.reverb); end
      for (int g = 0; g < int'(NUM_WAVE_GENS); g++) begin
         n_cmp++;
         if (r.wave_gens[g] !== sent.wave_gens[g]) begin
            n_err++; $display("FAIL lb_wavegen%0d: got %h want %h", g, r.wave_gens[g], sent.wave_gens[g]);
         end
      end
   endtask

`ifdef TX_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] want [2] = '{8'h00, 8'h01};
      for (int v = 0; v < 2; v++) begin
         conf_in = synth_t'({16{8'h5A}});
         if (v == 1) conf_in.reverb[7:0] = 8'h5B;
         tx_ready = 1'b1;
         start    = 1'b1;
         step();
         collect(-1);
         n_cmp++;
         if (got_data.size() !== FW + 1) begin
            n_err++; $display("FAIL cs_count%0d: got %0d want %0d", v, got_data.size(), FW + 1);
         end else begin
            n_cmp++;
            if (got_data[FW] !== want[v]) begin
               n_err++; $display("FAIL cs_word%0d: got %h want %h", v, got_data[FW], want[v]);
            end
            n_cmp++; if (got_last[FW] !== 1'b1) begin n_err++; $display("FAIL cs_last%0d: got %b want 1", v, got_last[FW]); end
            n_cmp++; if (got_last[FW-1] !== 1'b0) begin n_err++; $display("FAIL cs_payload_last%0d: got %b want 0", v, got_last[FW-1]); end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_restart_ignored();
      test_reset_mid_frame();
      test_loopback();
`ifdef TX_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
